// File: rtl/udp_loop_tx_sched.sv
// Read-side scheduler for the UDP echo payload FIFO: queues RX payload lengths,
// launches one TX frame per length, paces FIFO reads and enforces an inter-packet gap.
module udp_loop_tx_sched #(
    parameter int LEN_W      = 16,
    parameter int LQ_AW      = 2,
    parameter int IPG_CYCLES = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rx_pkt_done,
    input  logic [LEN_W-1:0] rx_byte_num,
    output logic             fifo_rd_en,
    input  logic             fifo_rd_empty,
    output logic             tx_start_en,
    output logic [LEN_W-1:0] tx_byte_num,
    input  logic             tx_req,
    input  logic             tx_done,
    output logic             busy,
    output logic             q_ovf,
    output logic             underrun,
    output logic             early_done,
    output logic [15:0]      pkt_cnt
);

    localparam int LQ_DEPTH = 1 << LQ_AW;
    localparam int GAP_W    = $clog2(IPG_CYCLES + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(IPG_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, START, SEND, WAIT_DONE, GAP} state_t;

    state_t             state, state_nxt;
    logic [LEN_W-1:0]   lq_mem [LQ_DEPTH];
    logic [LQ_AW-1:0]   lq_wr_ptr, lq_rd_ptr;
    logic [LQ_AW:0]     lq_count;
    logic [LEN_W-1:0]   rem;
    logic [GAP_W-1:0]   gap_cnt;

    logic lq_empty, lq_full, push_req, push, pop, drop, rem_zero, rem_last;
    logic under_evt, early_evt, done_evt;

    assign lq_empty = (lq_count == '0);
    assign lq_full  = (lq_count == (LQ_AW+1)'(LQ_DEPTH));
    assign push_req = rx_pkt_done & (rx_byte_num != '0);
    assign pop      = (state == IDLE) & ~lq_empty;
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign push     = push_req & (~lq_full | pop);
    assign drop     = push_req & lq_full & ~pop;
    assign rem_zero = (rem == '0);
    assign rem_last = (rem == LEN_W'(1));
    assign busy     = (state != IDLE);

    // NOTE: every output of this block gets a default first so no path infers a latch.
    always_comb begin
        state_nxt   = state;
        fifo_rd_en  = 1'b0;
        tx_start_en = 1'b0;
        under_evt   = 1'b0;
        early_evt   = 1'b0;
        done_evt    = 1'b0;
        case (state)
            IDLE:  if (pop) state_nxt = START;
            START: begin
                tx_start_en = 1'b1;
                state_nxt   = SEND;
            end
            SEND: begin
                fifo_rd_en = tx_req & ~rem_zero & ~fifo_rd_empty;
                under_evt  = tx_req & ~rem_zero & fifo_rd_empty;
                if (tx_done && !rem_zero) begin
                    early_evt = 1'b1;
                    state_nxt = GAP;
                end else if (rem_zero || (fifo_rd_en && rem_last)) begin
                    state_nxt = WAIT_DONE;
                end
            end
            WAIT_DONE: if (tx_done) begin
                done_evt  = 1'b1;
                state_nxt = GAP;
            end
            GAP:     if (gap_cnt == GAP_LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: queue storage is not reset; the pointers and count define which words are valid.
    always_ff @(posedge clk) begin
        if (push) lq_mem[lq_wr_ptr] <= rx_byte_num;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lq_wr_ptr <= '0;
            lq_rd_ptr <= '0;
            lq_count  <= '0;
        end else begin
            if (push) lq_wr_ptr <= lq_wr_ptr + 1'b1;
            if (pop)  lq_rd_ptr <= lq_rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   lq_count <= lq_count + 1'b1;
                2'b01:   lq_count <= lq_count - 1'b1;
                default: lq_count <= lq_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_byte_num <= '0;
            rem         <= '0;
            gap_cnt     <= '0;
            pkt_cnt     <= '0;
            q_ovf       <= 1'b0;
            underrun    <= 1'b0;
            early_done  <= 1'b0;
        end else begin
            if (pop) begin
                tx_byte_num <= lq_mem[lq_rd_ptr];
                rem         <= lq_mem[lq_rd_ptr];
            end else if (fifo_rd_en) begin
                rem <= rem - 1'b1;
            end
            gap_cnt <= (state == GAP) ? gap_cnt + 1'b1 : '0;
            if (done_evt)  pkt_cnt    <= pkt_cnt + 1'b1;
            if (drop)      q_ovf      <= 1'b1;
            if (under_evt) underrun   <= 1'b1;
            if (early_evt) early_done <= 1'b1;
        end
    end

endmodule

// File: tb/tb_udp_loop_tx_sched.sv
// Scoreboard bench for udp_loop_tx_sched: expected lengths are queued at push time
// and matched against tx_byte_num on every tx_start_en.
module tb_udp_loop_tx_sched;

    localparam int LEN_W = 16;
    localparam int IPG   = 12;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             rx_pkt_done = 1'b0;
    logic [LEN_W-1:0] rx_byte_num = '0;
    logic             fifo_rd_en;
    logic             fifo_rd_empty = 1'b0;
    logic             tx_start_en;
    logic [LEN_W-1:0] tx_byte_num;
    logic             tx_req = 1'b0;
    logic             tx_done = 1'b0;
    logic             busy;
    logic             q_ovf;
    logic             underrun;
    logic             early_done;
    logic [15:0]      pkt_cnt;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int starts = 0;
    int rd_cnt = 0;
    int start_cyc = 0;
    int push_cyc = 0;
    logic [LEN_W-1:0] sb[$];
    logic [LEN_W-1:0] mon_exp;

    udp_loop_tx_sched #(.LEN_W(LEN_W), .LQ_AW(2), .IPG_CYCLES(IPG)) dut (
        .clk(clk), .rst_n(rst_n),
        .rx_pkt_done(rx_pkt_done), .rx_byte_num(rx_byte_num),
        .fifo_rd_en(fifo_rd_en), .fifo_rd_empty(fifo_rd_empty),
        .tx_start_en(tx_start_en), .tx_byte_num(tx_byte_num),
        .tx_req(tx_req), .tx_done(tx_done),
        .busy(busy), .q_ovf(q_ovf), .underrun(underrun),
        .early_done(early_done), .pkt_cnt(pkt_cnt)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: counts reads and checks each start against the scoreboard head.
    always @(negedge clk) begin
        if (rst_n) begin
            if (fifo_rd_en) rd_cnt++;
            if (tx_start_en) begin
                starts++;
                start_cyc = cyc;
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL sb_start: unexpected start with tx_byte_num=%0d, none expected", tx_byte_num);
                end else begin
                    mon_exp = sb.pop_front();
                    if (tx_byte_num !== mon_exp) begin
                        bad++;
                        $display("FAIL sb_len: tx_byte_num=%0d expected %0d", tx_byte_num, mon_exp);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One clock step; single-cycle strobes drop back to 0 automatically.
    task automatic step();
        @(posedge clk);
        #1;
        rx_pkt_done = 1'b0;
        rx_byte_num = '0;
        tx_done     = 1'b0;
    endtask

    task automatic apply_reset();
        step();
        rst_n = 1'b0;
        tx_req = 1'b0;
        fifo_rd_empty = 1'b0;
        sb.delete();
        step();
        step();
        rst_n = 1'b1;
        rd_cnt = 0;
        starts = 0;
    endtask

    // Drive a length in the current cycle without advancing the clock.
    task automatic push_now(input int len, input bit queued);
        rx_pkt_done = 1'b1;
        rx_byte_num = LEN_W'(len);
        push_cyc = cyc;
        if (queued) sb.push_back(LEN_W'(len));
    endtask

    task automatic push_len(input int len, input bit queued);
        step();
        push_now(len, queued);
    endtask

    task automatic wait_start();
        int  n0 = starts;
        bit  seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (starts != n0) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL start_timeout: no tx_start_en within 60 clocks, starts=%0d", starts);
        end
    endtask

    // Hold tx_req until len reads are seen, idle two more clocks, then pulse tx_done.
    task automatic serve_pkt(input int len, output int reads, output int done_cyc);
        int rd0 = rd_cnt;
        tx_req = 1'b1;
        for (int i = 0; i < len + 20; i++) begin
            if (rd_cnt - rd0 >= len) break;
            step();
        end
        step();
        step();
        tx_req = 1'b0;
        reads = rd_cnt - rd0;
        step();
        tx_done = 1'b1;
        done_cyc = cyc;
    endtask

    task automatic wait_idle(output int idle_cyc);
        idle_cyc = -1;
        for (int i = 0; i < 60; i++) begin
            step();
            if (!busy) begin
                idle_cyc = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #2;
        total++;
        if ({fifo_rd_en, tx_start_en, busy, q_ovf, underrun, early_done} !== 6'b0) begin
            bad++;
            $display("FAIL reset_flags: got %b expected 000000",
                     {fifo_rd_en, tx_start_en, busy, q_ovf, underrun, early_done});
        end
        total++;
        if (tx_byte_num !== '0 || pkt_cnt !== '0) begin
            bad++;
            $display("FAIL reset_counts: tx_byte_num=%0d pkt_cnt=%0d expected 0 0", tx_byte_num, pkt_cnt);
        end
    endtask

    task automatic test_single();
        int p, reads, d, t;
        apply_reset();
        push_len(64, 1'b1);
        p = push_cyc;
        wait_start();
        total++;
        if (start_cyc - p !== 2) begin
            bad++;
            $display("FAIL single_latency: start %0d clocks after push, expected 2", start_cyc - p);
        end
        serve_pkt(64, reads, d);
        total++;
        if (reads !== 64) begin
            bad++;
            $display("FAIL single_reads: %0d reads expected 64", reads);
        end
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL single_busy_wait: busy=%b expected 1", busy);
        end
        wait_idle(t);
        total++;
        if (t - d !== IPG + 1) begin
            bad++;
            $display("FAIL single_gap: busy low %0d clocks after tx_done, expected %0d", t - d, IPG + 1);
        end
        total++;
        if (pkt_cnt !== 16'd1) begin
            bad++;
            $display("FAIL single_pkt_cnt: pkt_cnt=%0d expected 1", pkt_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int lens[3] = '{10, 20, 30};
        int reads, d, t;
        int prev_d = -1;
        apply_reset();
        foreach (lens[i]) push_len(lens[i], 1'b1);
        foreach (lens[i]) begin
            wait_start();
            if (prev_d >= 0) begin
                total++;
                if (start_cyc - prev_d < IPG + 2) begin
                    bad++;
                    $display("FAIL b2b_spacing: start %0d clocks after tx_done, need >= %0d", start_cyc - prev_d, IPG + 2);
                end
            end
            serve_pkt(lens[i], reads, d);
            prev_d = d;
            total++;
            if (reads !== lens[i]) begin
                bad++;
                $display("FAIL b2b_reads: pkt %0d got %0d reads expected %0d", i, reads, lens[i]);
            end
        end
        wait_idle(t);
        total++;
        if (pkt_cnt !== 16'd3 || sb.size() !== 0) begin
            bad++;
            $display("FAIL b2b_done: pkt_cnt=%0d pending=%0d expected 3 0", pkt_cnt, sb.size());
        end
    endtask

    task automatic test_overflow();
        int reads, d, t;
        apply_reset();
        push_len(50, 1'b1);
        wait_start();
        for (int i = 1; i <= 4; i++) push_len(i, 1'b1);
        step();
        total++;
        if (q_ovf !== 1'b0) begin
            bad++;
            $display("FAIL ovf_not_yet: q_ovf=%b expected 0 with 4 queued", q_ovf);
        end
        push_len(5, 1'b0);
        push_len(6, 1'b0);
        step();
        total++;
        if (q_ovf !== 1'b1) begin
            bad++;
            $display("FAIL ovf_flag: q_ovf=%b expected 1", q_ovf);
        end
        serve_pkt(50, reads, d);
        for (int i = 1; i <= 4; i++) begin
            wait_start();
            serve_pkt(i, reads, d);
            total++;
            if (reads !== i) begin
                bad++;
                $display("FAIL ovf_reads: len %0d got %0d reads", i, reads);
            end
        end
        for (int i = 0; i < 40; i++) step();
        total++;
        if (starts !== 5 || sb.size() !== 0) begin
            bad++;
            $display("FAIL ovf_starts: starts=%0d pending=%0d expected 5 0", starts, sb.size());
        end
    endtask

    task automatic test_full_push_pop();
        int lens[5] = '{1, 2, 3, 4, 77};
        int reads, d, t;
        apply_reset();
        push_len(30, 1'b1);
        wait_start();
        for (int i = 1; i <= 4; i++) push_len(i, 1'b1);
        serve_pkt(30, reads, d);
        wait_idle(t);
        push_now(77, 1'b1);
        step();
        total++;
        if (q_ovf !== 1'b0) begin
            bad++;
            $display("FAIL fullpp_ovf: q_ovf=%b expected 0", q_ovf);
        end
        foreach (lens[i]) begin
            wait_start();
            serve_pkt(lens[i], reads, d);
        end
        wait_idle(t);
        total++;
        if (pkt_cnt !== 16'd6 || sb.size() !== 0) begin
            bad++;
            $display("FAIL fullpp_done: pkt_cnt=%0d pending=%0d expected 6 0", pkt_cnt, sb.size());
        end
    endtask

    task automatic test_underrun();
        int rd0, t;
        apply_reset();
        push_len(8, 1'b1);
        wait_start();
        rd0 = rd_cnt;
        tx_req = 1'b1;
        step();
        step();
        fifo_rd_empty = 1'b1;
        total++;
        if (underrun !== 1'b0) begin
            bad++;
            $display("FAIL under_early: underrun=%b expected 0", underrun);
        end
        step();
        total++;
        if (underrun !== 1'b1) begin
            bad++;
            $display("FAIL under_flag: underrun=%b expected 1", underrun);
        end
        step();
        fifo_rd_empty = 1'b0;
        total++;
        if (rd_cnt - rd0 !== 2) begin
            bad++;
            $display("FAIL under_stall: %0d reads expected 2", rd_cnt - rd0);
        end
        for (int i = 0; i < 20; i++) begin
            if (rd_cnt - rd0 >= 8) break;
            step();
        end
        step();
        step();
        tx_req = 1'b0;
        total++;
        if (rd_cnt - rd0 !== 8) begin
            bad++;
            $display("FAIL under_total: %0d reads expected 8", rd_cnt - rd0);
        end
        step();
        tx_done = 1'b1;
        wait_idle(t);
        total++;
        if (pkt_cnt !== 16'd1 || underrun !== 1'b1) begin
            bad++;
            $display("FAIL under_done: pkt_cnt=%0d underrun=%b expected 1 1", pkt_cnt, underrun);
        end
    endtask

    task automatic test_early_done();
        int rd0, d, t;
        apply_reset();
        push_len(100, 1'b1);
        wait_start();
        rd0 = rd_cnt;
        tx_req = 1'b1;
        for (int i = 0; i < 80; i++) begin
            if (rd_cnt - rd0 >= 40) break;
            step();
        end
        tx_req = 1'b0;
        tx_done = 1'b1;
        d = cyc;
        step();
        tx_req = 1'b1;
        wait_idle(t);
        tx_req = 1'b0;
        total++;
        if (t - d !== IPG + 1) begin
            bad++;
            $display("FAIL early_gap: idle %0d clocks after tx_done, expected %0d", t - d, IPG + 1);
        end
        total++;
        if (rd_cnt - rd0 !== 40) begin
            bad++;
            $display("FAIL early_reads: %0d reads expected 40", rd_cnt - rd0);
        end
        total++;
        if (early_done !== 1'b1 || pkt_cnt !== 16'd0) begin
            bad++;
            $display("FAIL early_flags: early_done=%b pkt_cnt=%0d expected 1 0", early_done, pkt_cnt);
        end
    endtask

    task automatic test_zero_len();
        apply_reset();
        push_len(0, 1'b0);
        for (int i = 0; i < 10; i++) step();
        total++;
        if (starts !== 0 || busy !== 1'b0 || q_ovf !== 1'b0) begin
            bad++;
            $display("FAIL zero_len: starts=%0d busy=%b q_ovf=%b expected 0 0 0", starts, busy, q_ovf);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        push_len(20, 1'b1);
        wait_start();
        tx_req = 1'b1;
        step();
        step();
        step();
        total++;
        if (fifo_rd_en !== 1'b1) begin
            bad++;
            $display("FAIL arst_pre: fifo_rd_en=%b expected 1 mid-SEND", fifo_rd_en);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({fifo_rd_en, tx_start_en, busy, q_ovf, underrun, early_done} !== 6'b0 ||
            tx_byte_num !== '0 || pkt_cnt !== '0) begin
            bad++;
            $display("FAIL arst_outputs: flags=%b tx_byte_num=%0d pkt_cnt=%0d expected all 0",
                     {fifo_rd_en, tx_start_en, busy, q_ovf, underrun, early_done}, tx_byte_num, pkt_cnt);
        end
        tx_req = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_full_push_pop();
        test_underrun();
        test_early_done();
        test_zero_len();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
